// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage plus IF/ID pipeline register for the 16-bit,
//   4-bit-opcode CPU. Owns the PC, drives a variable-latency instruction
//   memory via a req/ready handshake, and presents a registered instruction,
//   opcode and pc+2 to decode. Handles stall, branch redirect and HLT (4'hF).
//
//   Optional feature macro: FETCH_PREDECODE_EN
//     When defined, adds registered ifid_is_mem (opcode 1000/1001) and
//     ifid_is_branch (opcode 1100/1101) outputs that track ifid_instr.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   stall             decode cannot accept; IF/ID holds
//   branch_taken      one-cycle redirect pulse, branch_target valid with it
//   imem_req/addr     registered request; held until imem_ready
//   imem_ready/rdata  response strobe and data
//   ifid_valid/instr/opcode/pc_plus2   IF/ID register contents
//   pc                current fetch PC
//   halted            HLT has reached IF/ID; fetch stopped
// -----------------------------------------------------------------------------
// state  | meaning
// FETCH  | issue request for pc (imem_req rises next cycle)
// WAIT   | request outstanding; waiting for imem_ready
// HOLD   | response parked in skid buffer while decode stalls
// HALT   | HLT in IF/ID; idle until redirect or reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [3:0]         ifid_opcode,
  output logic [ADDR_W-1:0]  ifid_pc_plus2,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_PREDECODE_EN
  ,
  output logic               ifid_is_mem,
  output logic               ifid_is_branch
`endif
);

  localparam logic [3:0]        OP_HLT  = 4'hF;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic                drop, drop_d;
  logic [ADDR_W-1:0]   pc_d, addr_d, pc2_d, skid_pc2, skid_pc2_d;
  logic [INSTR_W-1:0]  instr_d, skid_instr, skid_instr_d;
  logic                req_d, valid_d, halted_d, load_ifid;
  logic [ADDR_W-1:0]   pc_inc;

  assign pc_inc      = pc + PC_STEP;  // wraps naturally at 2^ADDR_W
  assign ifid_opcode = ifid_instr[INSTR_W-1 -: 4];

  always_comb begin
    state_d      = state;
    drop_d       = drop;
    pc_d         = pc;
    req_d        = imem_req;
    addr_d       = imem_addr;
    valid_d      = ifid_valid;
    instr_d      = ifid_instr;
    pc2_d        = ifid_pc_plus2;
    halted_d     = halted;
    skid_instr_d = skid_instr;
    skid_pc2_d   = skid_pc2;
    load_ifid    = 1'b0;

    if (branch_taken) begin
      pc_d         = branch_target;
      valid_d      = 1'b0;
      halted_d     = 1'b0;
      skid_instr_d = '0;
      skid_pc2_d   = '0;
      // An outstanding request is never aborted: keep req/addr and discard
      // its response later. A response landing in the redirect cycle itself
      // is simply thrown away here.
      if (state == S_WAIT && !imem_ready) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        req_d   = 1'b0;
        state_d = S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_ready) begin
            req_d = 1'b0;
            if (drop) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              pc_d = pc_inc;
              if (!stall) begin
                load_ifid = 1'b1;
                valid_d   = 1'b1;
                instr_d   = imem_rdata;
                pc2_d     = pc_inc;
                if (imem_rdata[INSTR_W-1 -: 4] == OP_HLT) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
                end else begin
                  state_d  = S_FETCH;
                end
              end else begin
                skid_instr_d = imem_rdata;
                skid_pc2_d   = pc_inc;
                state_d      = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_ifid = 1'b1;
            valid_d   = 1'b1;
            instr_d   = skid_instr;
            pc2_d     = skid_pc2;
            if (skid_instr[INSTR_W-1 -: 4] == OP_HLT) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              state_d  = S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop          <= 1'b0;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc_plus2 <= '0;
      halted        <= 1'b0;
      skid_instr    <= '0;
      skid_pc2      <= '0;
    end else begin
      drop          <= drop_d;
      pc            <= pc_d;
      imem_req      <= req_d;
      imem_addr     <= addr_d;
      ifid_valid    <= valid_d;
      ifid_instr    <= instr_d;
      ifid_pc_plus2 <= pc2_d;
      halted        <= halted_d;
      skid_instr    <= skid_instr_d;
      skid_pc2      <= skid_pc2_d;
    end
  end

`ifdef FETCH_PREDECODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_is_mem    <= 1'b0;
      ifid_is_branch <= 1'b0;
    end else if (branch_taken) begin
      ifid_is_mem    <= 1'b0;
      ifid_is_branch <= 1'b0;
    end else if (load_ifid) begin
      ifid_is_mem    <= (instr_d[INSTR_W-1 -: 3] == 3'b100);
      ifid_is_branch <= (instr_d[INSTR_W-1 -: 3] == 3'b110);
    end
  end
`endif

endmodule
